elevator_shaft_model: RTL



---
 rtl/elevator_shaft_model_if.sv | 36 +++
 rtl/elevator_shaft_model.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/elevator_shaft_model_if.sv
// Command/status bundle between the elevator controller (master) and the shaft plant (slave).
// ELEVATOR_CABIN_TEMP_EN adds the cabin heater/cooler commands and the temperature readback.
interface elevator_shaft_model_if;
  logic        motor_up;
  logic        motor_down;
  logic        door;
  logic [31:0] position;
  logic        at_floor;
  logic        moving;
  logic        door_open;
  logic        fault;
  logic [2:0]  fault_code;
`ifdef ELEVATOR_CABIN_TEMP_EN
  logic               heater;
  logic               cooler;
  logic signed [31:0] temp;

  modport master (
    output motor_up, motor_down, door, heater, cooler,
    input  position, at_floor, moving, door_open, fault, fault_code, temp
  );
  modport slave (
    input  motor_up, motor_down, door, heater, cooler,
    output position, at_floor, moving, door_open, fault, fault_code, temp
  );
`else
  modport master (
    output motor_up, motor_down, door,
    input  position, at_floor, moving, door_open, fault, fault_code
  );
  modport slave (
    input  motor_up, motor_down, door,
    output position, at_floor, moving, door_open, fault, fault_code
  );
`endif
endinterface

// File: rtl/elevator_shaft_model.sv
// Cabin/shaft plant model: turns motor and door commands into floor position, arrival and faults.
// Optional cabin temperature model is compiled in when ELEVATOR_CABIN_TEMP_EN is defined.
module elevator_shaft_model #(
  parameter int unsigned FLOOR_COUNT     = 10,
  parameter int unsigned TICKS_PER_FLOOR = 8,
  parameter int unsigned DOOR_TICKS      = 4,
  parameter int unsigned START_FLOOR     = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  elevator_shaft_model_if.slave  bus
);
  typedef enum logic [2:0] {StIdle, StMoveUp, StMoveDown, StDoorOpen, StFault} state_e;

  localparam logic [31:0] TopFloor = 32'(FLOOR_COUNT - 1);
  localparam logic [31:0] LastTick = 32'(TICKS_PER_FLOOR - 1);
  localparam logic [31:0] DwellMax = 32'(DOOR_TICKS);

  state_e      state_q, state_d;
  logic [31:0] pos_q, pos_d;
  logic [31:0] travel_q, travel_d;
  logic [31:0] dwell_q, dwell_d, dwell_inc;
  logic        at_floor_q, at_floor_d;
  logic [2:0]  code_q, code_d, fault_det;
  logic        mu, md, dr, any_motor;

  assign mu        = bus.motor_up;
  assign md        = bus.motor_down;
  assign dr        = bus.door;
  assign any_motor = mu | md;

  // Lowest code wins, so the checks are ordered by code.
  always_comb begin
    fault_det = 3'd0;
    if (mu && md) begin
      fault_det = 3'd1;
    end else if ((dr && any_motor) || (any_motor && state_q == StDoorOpen)) begin
      fault_det = 3'd2;
    end else if ((mu && pos_q == TopFloor) || (md && pos_q == '0)) begin
      fault_det = 3'd3;
    end else if (travel_q != '0 &&
                 ((state_q == StMoveUp && !mu) || (state_q == StMoveDown && !md))) begin
      fault_det = 3'd4;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    travel_d   = travel_q;
    dwell_d    = dwell_q;
    code_d     = code_q;
    at_floor_d = 1'b0;
    dwell_inc  = (dwell_q >= DwellMax) ? DwellMax : dwell_q + 32'd1;
    if (state_q != StFault) begin
      if (fault_det != 3'd0) begin
        state_d = StFault;
        code_d  = fault_det;
      end else begin
        unique case (state_q)
          // The sampled command cycle that starts travel is the first tick of drive.
          StIdle: begin
            if (mu) begin
              state_d  = StMoveUp;
              travel_d = 32'd1;
            end else if (md) begin
              state_d  = StMoveDown;
              travel_d = 32'd1;
            end else if (dr) begin
              state_d = StDoorOpen;
              dwell_d = '0;
            end
          end
          StMoveUp: begin
            if (!mu) begin
              state_d = StIdle;
            end else if (travel_q == LastTick) begin
              pos_d      = pos_q + 32'd1;
              travel_d   = '0;
              at_floor_d = 1'b1;
            end else begin
              travel_d = travel_q + 32'd1;
            end
          end
          StMoveDown: begin
            if (!md) begin
              state_d = StIdle;
            end else if (travel_q == LastTick) begin
              pos_d      = pos_q - 32'd1;
              travel_d   = '0;
              at_floor_d = 1'b1;
            end else begin
              travel_d = travel_q + 32'd1;
            end
          end
          StDoorOpen: begin
            dwell_d = dwell_inc;
            if (!dr && dwell_inc >= DwellMax) state_d = StIdle;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      pos_q      <= 32'(START_FLOOR);
      travel_q   <= '0;
      dwell_q    <= '0;
      at_floor_q <= 1'b0;
      code_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      travel_q   <= travel_d;
      dwell_q    <= dwell_d;
      at_floor_q <= at_floor_d;
      code_q     <= code_d;
    end
  end

  assign bus.position   = pos_q;
  assign bus.at_floor   = at_floor_q;
  assign bus.moving     = (state_q == StMoveUp) || (state_q == StMoveDown);
  assign bus.door_open  = (state_q == StDoorOpen);
  assign bus.fault      = (state_q == StFault);
  assign bus.fault_code = code_q;

`ifdef ELEVATOR_CABIN_TEMP_EN
  localparam logic signed [31:0] TempHome = 32'sd25;
  localparam logic signed [31:0] TempMax  = 32'sd85;
  localparam logic signed [31:0] TempMin  = -32'sd40;

  logic [1:0]         presc_q, presc_d;
  logic signed [31:0] temp_q, temp_d;

  // Temperature steps once every four clocks; the prescaler freezes with the plant in fault.
  always_comb begin
    presc_d = presc_q;
    temp_d  = temp_q;
    if (state_q != StFault) begin
      presc_d = presc_q + 2'd1;
      if (presc_q == 2'd3) begin
        if (bus.heater && !bus.cooler) begin
          if (temp_q < TempMax) temp_d = temp_q + 32'sd1;
        end else if (bus.cooler && !bus.heater) begin
          if (temp_q > TempMin) temp_d = temp_q - 32'sd1;
        end else if (temp_q > TempHome) begin
          temp_d = temp_q - 32'sd1;
        end else if (temp_q < TempHome) begin
          temp_d = temp_q + 32'sd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= 2'd0;
      temp_q  <= TempHome;
    end else begin
      presc_q <= presc_d;
      temp_q  <= temp_d;
    end
  end

  assign bus.temp = temp_q;
`endif
endmodule
